// File: rtl/up_boot_ctrl_if.sv
// Byte-stream handshake from the program source plus the load/interrupt lines to the core.
// The controller connects through the master modport and the source/core side through slave.
interface up_boot_ctrl_if;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       load;
  logic [7:0] mem_in;
  logic       core_int;

  modport master (
    input  src_data, src_valid,
    output src_ready, load, mem_in, core_int
  );

  modport slave (
    output src_data, src_valid,
    input  src_ready, load, mem_in, core_int
  );
endinterface

// File: rtl/up_boot_ctrl.sv
// Boot controller: streams NBYTES program bytes into a core, waits SETTLE cycles,
// then runs the core with an optional periodic active-low interrupt.
module up_boot_ctrl #(
  parameter int NBYTES     = 256,
  parameter int SETTLE     = 4,
  parameter int INT_PERIOD = 100,
  parameter int INT_LOW    = 50
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           int_en,
  up_boot_ctrl_if.master bus,
  output logic           busy,
  output logic           done,
  output logic [8:0]     byte_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN} state_t;

  localparam logic [8:0]  NBYTES_C    = 9'(NBYTES);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [15:0] PERIOD_LAST = 16'(INT_PERIOD - 1);
  localparam logic [15:0] INT_LOW_C   = 16'(INT_LOW);

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] phase_q, phase_d;
  logic [7:0]  mem_in_q, mem_in_d;
  logic        load_q, load_d;
  logic        ready_q, ready_d;
  logic        int_q, int_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        xfer;

  assign xfer          = bus.src_valid && ready_q;
  assign bus.src_ready = ready_q;
  assign bus.load      = load_q;
  assign bus.mem_in    = mem_in_q;
  assign bus.core_int  = int_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign byte_cnt      = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 9'd0;
      settle_q <= 8'd0;
      phase_q  <= 16'd0;
      mem_in_q <= 8'h00;
      load_q   <= 1'b0;
      ready_q  <= 1'b0;
      int_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      phase_q  <= phase_d;
      mem_in_q <= mem_in_d;
      load_q   <= load_d;
      ready_q  <= ready_d;
      int_q    <= int_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Every output is computed here one cycle ahead so the registered copies line up.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = 8'd0;
    phase_d  = 16'd0;
    mem_in_d = mem_in_q;
    load_d   = 1'b0;
    ready_d  = 1'b0;
    int_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = 9'd0;
          ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        ready_d = 1'b1;
        if (xfer && cnt_q < NBYTES_C) begin
          load_d   = 1'b1;
          mem_in_d = bus.src_data;
          cnt_d    = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == NBYTES_C) begin
            state_d = S_SETTLE;
            ready_d = 1'b0;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_RUN;
          int_d   = !int_en;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      S_RUN: begin
        // A restart drops any interrupt pulse in progress immediately.
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = 9'd0;
          ready_d = 1'b1;
        end else begin
          phase_d = (phase_q == PERIOD_LAST) ? 16'd0 : phase_q + 16'd1;
          int_d   = !(int_en && phase_d < INT_LOW_C);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_SETTLE);
    done_d = (state_d == S_RUN);
  end

endmodule
